// File: rtl/prg_ram_injector_if.sv
// Bundles the ioctl download stream and the C64 RAM write port of prg_ram_injector.
// Handshakes: ioctl_wr is a one-cycle valid, taken only while ioctl_wait is low;
// ram_req is a level valid held with ram_addr/ram_dout stable until a one-cycle ram_ack.
interface prg_ram_injector_if;
  logic        ioctl_download;
  logic        load_prg;
  logic [22:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic        ioctl_wait;
  logic [15:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_req;
  logic        ram_ack;

  modport master (
    output ioctl_download, load_prg, ioctl_addr, ioctl_data, ioctl_wr, ram_ack,
    input  ioctl_wait, ram_addr, ram_dout, ram_req
  );

  modport slave (
    input  ioctl_download, load_prg, ioctl_addr, ioctl_data, ioctl_wr, ram_ack,
    output ioctl_wait, ram_addr, ram_dout, ram_req
  );
endinterface

// File: rtl/prg_ram_injector.sv
// Streams a PRG image (2-byte load address + payload) from ioctl into C64 RAM.
// Define PRG_BASIC_PTR_EN to also patch the BASIC end pointers with prg_end afterwards.
module prg_ram_injector #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  prg_ram_injector_if.slave        bus,
  output logic [15:0]              prg_end,
  output logic                     prg_done,
  output logic                     prg_err,
  output logic [2:0]               state_dbg
);
  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

  typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, WRITE, PTR, DONE, ERR} state_t;

  state_t         state;
  logic [7:0]     load_lo;
  logic [15:0]    wp;
  logic           wrapped;
  logic [22:0]    exp_cnt;
  logic           qual_q;
  logic [TW-1:0]  timer;
  logic [15:0]    ram_addr_q;
  logic [7:0]     ram_dout_q;
  logic           ram_req_q;
  logic           ioctl_wait_q;

  logic wr;
  logic qual;
  logic addr_bad;

  assign wr       = bus.ioctl_wr & bus.load_prg;
  assign qual     = bus.ioctl_download & bus.load_prg;
  assign addr_bad = wr && (bus.ioctl_addr != exp_cnt);

  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_dout   = ram_dout_q;
  assign bus.ram_req    = ram_req_q;
  assign bus.ioctl_wait = ioctl_wait_q;
  assign state_dbg      = state;

`ifdef PRG_BASIC_PTR_EN
  logic        ptr_phase;
  logic [2:0]  ptr_idx;
  logic [15:0] ptr_base;
  always_comb begin
    ptr_base = 16'h00AE;
    case (ptr_idx[2:1])
      2'd0:    ptr_base = 16'h002D;
      2'd1:    ptr_base = 16'h002F;
      2'd2:    ptr_base = 16'h0031;
      default: ptr_base = 16'h00AE;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      load_lo      <= '0;
      wp           <= '0;
      wrapped      <= 1'b0;
      exp_cnt      <= '0;
      // A download already in progress across reset must not look like a fresh start.
      qual_q       <= 1'b1;
      timer        <= '0;
      ram_addr_q   <= '0;
      ram_dout_q   <= '0;
      ram_req_q    <= 1'b0;
      ioctl_wait_q <= 1'b0;
      prg_end      <= '0;
      prg_done     <= 1'b0;
      prg_err      <= 1'b0;
`ifdef PRG_BASIC_PTR_EN
      ptr_phase    <= 1'b0;
      ptr_idx      <= '0;
`endif
    end else begin
      qual_q   <= qual;
      prg_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (qual && !qual_q) begin
            state   <= HDR_LO;
            prg_err <= 1'b0;
            exp_cnt <= '0;
            wrapped <= 1'b0;
`ifdef PRG_BASIC_PTR_EN
            ptr_phase <= 1'b0;
`endif
          end
        end
        HDR_LO: begin
          if (wr) begin
            load_lo <= bus.ioctl_data;
            exp_cnt <= exp_cnt + 23'd1;
            if (addr_bad) prg_err <= 1'b1;
            state   <= HDR_HI;
          end else if (!bus.ioctl_download) begin
            prg_err <= 1'b1;
            state   <= ERR;
          end
        end
        HDR_HI: begin
          if (wr) begin
            wp      <= {bus.ioctl_data, load_lo};
            exp_cnt <= exp_cnt + 23'd1;
            if (addr_bad) prg_err <= 1'b1;
            state   <= DATA;
          end else if (!bus.ioctl_download) begin
            prg_err <= 1'b1;
            state   <= ERR;
          end
        end
        DATA: begin
          // A byte arriving with the falling download edge is written first; the level
          // check then ends the image once WRITE hands back.
          if (wr) begin
            exp_cnt <= exp_cnt + 23'd1;
            if (addr_bad || wrapped) prg_err <= 1'b1;
            if (!wrapped) begin
              ram_addr_q   <= wp;
              ram_dout_q   <= bus.ioctl_data;
              ram_req_q    <= 1'b1;
              ioctl_wait_q <= 1'b1;
              timer        <= '0;
              state        <= WRITE;
            end
          end else if (!bus.ioctl_download) begin
            prg_end <= wp;
            state   <= PTR;
`ifdef PRG_BASIC_PTR_EN
            ptr_idx <= '0;
`endif
          end
        end
        WRITE: begin
          if (wr) prg_err <= 1'b1;
          if (bus.ram_ack) begin
            ram_req_q    <= 1'b0;
            ioctl_wait_q <= 1'b0;
`ifdef PRG_BASIC_PTR_EN
            if (ptr_phase) begin
              if (ptr_idx == 3'd7) state <= DONE;
              else begin
                ptr_idx <= ptr_idx + 3'd1;
                state   <= PTR;
              end
            end else begin
              wp <= wp + 16'd1;
              if (wp == 16'hFFFF) wrapped <= 1'b1;
              state <= DATA;
            end
`else
            wp <= wp + 16'd1;
            if (wp == 16'hFFFF) wrapped <= 1'b1;
            state <= DATA;
`endif
          end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
            ram_req_q    <= 1'b0;
            ioctl_wait_q <= 1'b0;
            prg_err      <= 1'b1;
            state        <= ERR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        PTR: begin
`ifdef PRG_BASIC_PTR_EN
          ram_addr_q   <= ptr_base + {15'd0, ptr_idx[0]};
          ram_dout_q   <= ptr_idx[0] ? prg_end[15:8] : prg_end[7:0];
          ram_req_q    <= 1'b1;
          ioctl_wait_q <= 1'b1;
          timer        <= '0;
          ptr_phase    <= 1'b1;
          state        <= WRITE;
`else
          state <= DONE;
`endif
        end
        DONE: begin
          prg_done <= 1'b1;
          state    <= IDLE;
        end
        ERR: begin
          ram_req_q    <= 1'b0;
          ioctl_wait_q <= 1'b0;
          if (!bus.ioctl_download) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
